// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared constants and FSM state type for the dispatch scheduler.
package dispatch_pkg;
  localparam int DEF_TAG_W = 5;
  localparam int DEF_EXU_W = 3;
  localparam logic [DEF_TAG_W-1:0] TAG_INVALID = '1;
  localparam logic [DEF_EXU_W-1:0] EX_ERR_UNIT = '1;
  typedef enum logic {RUN, WAIT_JUMP} disp_state_t;
endpackage

// File: rtl/dispatch_sched_ring.sv
// rob_tag_ring: circular ROB tag allocator with in-order commit checking.
module rob_tag_ring #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc,
  input  logic                     flush,
  input  logic                     commit_valid,
  input  logic [TAG_W-1:0]         commit_tag,
  output logic [$clog2(DEPTH)-1:0] tail,
  output logic [TAG_W-1:0]         count,
  output logic                     full,
  output logic                     order_err
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] head;
  logic empty, free;
  assign empty = count == '0;
  assign full = count == TAG_W'(DEPTH);
  assign free = commit_valid & !empty & (commit_tag == TAG_W'(head));
  always_ff @(posedge clk)
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      order_err <= 1'b0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + PW'(free);
      tail <= tail + PW'(alloc);
      count <= count + TAG_W'(alloc) - TAG_W'(free);
      order_err <= order_err | (commit_valid & !free);
    end
endmodule

// File: rtl/dispatch_sched.sv
// dispatch_sched: decode-to-issue dispatch gate with ROB tag allocation and jump blocking.
// Optional DISPATCH_PERF_CNT_EN adds saturating stall-cause counters.
module dispatch_sched import dispatch_pkg::*; #(
  parameter int ROB_DEPTH   = 16,
  parameter int TAG_W       = DEF_TAG_W,
  parameter int EX_UNIT_NUM = 4,
  parameter int EXU_W       = DEF_EXU_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec_valid,
  input  logic [EXU_W-1:0]       dec_ex_unit,
  input  logic                   dec_is_jump,
  output logic                   dec_ready,
  input  logic [EX_UNIT_NUM-1:0] rs_full,
  output logic                   disp_fire,
  output logic [TAG_W-1:0]       disp_tag,
  output logic [EX_UNIT_NUM-1:0] disp_unit,
  input  logic                   commit_valid,
  input  logic [TAG_W-1:0]       commit_tag,
  input  logic                   br_resolve,
  input  logic                   flush,
  output logic                   rob_full,
  output logic [TAG_W-1:0]       rob_count,
  output logic                   jump_stall,
`ifdef DISPATCH_PERF_CNT_EN
  output logic [31:0]            perf_rob_stall,
  output logic [31:0]            perf_rs_stall,
  output logic [31:0]            perf_jump_stall,
`endif
  output logic                   order_err
);
  disp_state_t state, state_nx;
  logic [$clog2(ROB_DEPTH)-1:0] tail;
  logic [EX_UNIT_NUM-1:0] onehot;
  logic unit_ok, rs_blk;
  // out-of-range codes (including the ERR code) shift out to zero and become bubbles
  assign onehot = {{(EX_UNIT_NUM-1){1'b0}}, 1'b1} << dec_ex_unit;
  assign unit_ok = |onehot;
  assign rs_blk = |(onehot & rs_full);
  assign disp_fire = !rst & dec_valid & (state == RUN) & !rob_full & unit_ok & !rs_blk & !flush;
  assign dec_ready = !dec_valid | disp_fire | !unit_ok;
  assign disp_tag = disp_fire ? TAG_W'(tail) : {TAG_W{1'b1}};
  assign disp_unit = disp_fire ? onehot : '0;
  assign jump_stall = state == WAIT_JUMP;
  always_comb
    state_nx = flush ? RUN :
               (state == RUN) ? ((disp_fire & dec_is_jump) ? WAIT_JUMP : RUN) :
               (br_resolve ? RUN : WAIT_JUMP);
  always_ff @(posedge clk)
    state <= rst ? RUN : state_nx;
  rob_tag_ring #(.DEPTH(ROB_DEPTH), .TAG_W(TAG_W)) u_ring (
    .clk(clk),
    .rst(rst),
    .alloc(disp_fire),
    .flush(flush),
    .commit_valid(commit_valid),
    .commit_tag(commit_tag),
    .tail(tail),
    .count(rob_count),
    .full(rob_full),
    .order_err(order_err)
  );
`ifdef DISPATCH_PERF_CNT_EN
  logic stalled;
  assign stalled = dec_valid & !disp_fire & unit_ok;
  always_ff @(posedge clk)
    if (rst) begin
      perf_rob_stall <= '0;
      perf_rs_stall <= '0;
      perf_jump_stall <= '0;
    end else if (stalled) begin
      if (state == WAIT_JUMP) perf_jump_stall <= perf_jump_stall + 32'(perf_jump_stall != '1);
      else if (rob_full) perf_rob_stall <= perf_rob_stall + 32'(perf_rob_stall != '1);
      else if (rs_blk) perf_rs_stall <= perf_rs_stall + 32'(perf_rs_stall != '1);
    end
`endif
endmodule

// File: tb/tb_dispatch_sched.sv
// tb_dispatch_sched: directed plan scenarios plus random traffic against a queue-based ROB model.
module tb_dispatch_sched;
  logic clk = 0, rst = 1;
  logic dec_valid = 0, dec_is_jump = 0, commit_valid = 0, br_resolve = 0, flush = 0;
  logic [2:0] dec_ex_unit = 0;
  logic [3:0] rs_full = 0;
  logic [4:0] commit_tag = 0;
  logic dec_ready, disp_fire, rob_full, jump_stall, order_err;
  logic [4:0] disp_tag, rob_count;
  logic [3:0] disp_unit;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] perf_rob_stall, perf_rs_stall, perf_jump_stall;
  int m_prob = 0, m_prs = 0, m_pjmp = 0;
`endif
  int n_checks = 0, n_pass = 0;
  int m_q[$];
  int m_tail = 0;
  bit m_wait = 0, m_err = 0;

  dispatch_sched dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ex_unit(dec_ex_unit),
    .dec_is_jump(dec_is_jump), .dec_ready(dec_ready), .rs_full(rs_full),
    .disp_fire(disp_fire), .disp_tag(disp_tag), .disp_unit(disp_unit),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .br_resolve(br_resolve),
    .flush(flush), .rob_full(rob_full), .rob_count(rob_count), .jump_stall(jump_stall),
`ifdef DISPATCH_PERF_CNT_EN
    .perf_rob_stall(perf_rob_stall), .perf_rs_stall(perf_rs_stall),
    .perf_jump_stall(perf_jump_stall),
`endif
    .order_err(order_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic cycle(input bit v, input int u, input bit j, input logic [3:0] rsf,
                       input bit cv, input int ct, input bit br, input bit fl, input bit r);
    bit ok, e_fire, e_ready;
    @(negedge clk);
    dec_valid = v; dec_ex_unit = 3'(u); dec_is_jump = j; rs_full = rsf;
    commit_valid = cv; commit_tag = 5'(ct); br_resolve = br; flush = fl; rst = r;
    #1;
    ok = u < 4;
    e_fire = !r && v && !m_wait && m_q.size() < 16 && ok && !rsf[u%4] && !fl;
    e_ready = !v || e_fire || !ok;
    check("disp_fire", 32'(disp_fire), 32'(e_fire));
    check("disp_tag", 32'(disp_tag), e_fire ? 32'(m_tail) : 32'd31);
    check("disp_unit", 32'(disp_unit), e_fire ? 32'(1 << u) : 32'd0);
    check("dec_ready", 32'(dec_ready), 32'(e_ready));
    check("rob_full", 32'(rob_full), 32'(m_q.size() == 16));
    check("rob_count", 32'(rob_count), 32'(m_q.size()));
    check("jump_stall", 32'(jump_stall), 32'(m_wait));
    check("order_err", 32'(order_err), 32'(m_err));
`ifdef DISPATCH_PERF_CNT_EN
    check("perf_rob", perf_rob_stall, 32'(m_prob));
    check("perf_rs", perf_rs_stall, 32'(m_prs));
    check("perf_jump", perf_jump_stall, 32'(m_pjmp));
    if (r) begin m_prob = 0; m_prs = 0; m_pjmp = 0; end
    else if (v && !e_fire && ok) begin
      if (m_wait) m_pjmp++;
      else if (m_q.size() == 16) m_prob++;
      else if (rsf[u%4]) m_prs++;
    end
`endif
    if (r) begin
      m_q.delete(); m_tail = 0; m_wait = 0; m_err = 0;
    end else if (fl) begin
      m_q.delete(); m_tail = 0; m_wait = 0;
    end else begin
      if (cv) begin
        if (m_q.size() > 0 && ct == m_q[0]) void'(m_q.pop_front());
        else m_err = 1;
      end
      if (e_fire) begin m_q.push_back(m_tail); m_tail = (m_tail + 1) % 16; end
      if (m_wait && br) m_wait = 0;
      if (e_fire && j) m_wait = 1;
    end
  endtask

  initial begin
    int head;
    repeat (2) @(posedge clk);
    // fill the ROB with ALU ops, then a 17th must wait
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // jump gets tag 3, followers stall until resolve
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1, 0, 0);
    // RS full for unit 2, then released
    cycle(1, 2, 0, 4'b0100, 0, 0, 0, 0, 0);
    cycle(1, 2, 0, 4'b0000, 0, 0, 0, 0, 0);
    // flush with coincident commit, then dispatch from tag 0, then commit on empty
    cycle(0, 0, 0, 0, 1, 0, 0, 1, 0);
    cycle(1, 3, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 5, 0, 0, 0);
    // ERR unit bubble and other out-of-range codes
    cycle(1, 7, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 5, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      int u, ct;
      u = ($urandom_range(0, 7) < 6) ? $urandom_range(0, 3) : $urandom_range(0, 7);
      head = (m_q.size() > 0) ? m_q[0] : 0;
      ct = (m_q.size() > 0 && $urandom_range(0, 15) != 0) ? head : $urandom_range(0, 31);
      cycle($urandom_range(0, 3) != 0, u, $urandom_range(0, 5) == 0,
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0,
            $urandom_range(0, 2) == 0, ct, $urandom_range(0, 3) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
